// File: rtl/pc_stack_unit.sv
// Program counter with jump, call/return and an internal return-address stack.
// One action per enabled edge: jump > call > ret > increment.
module pc_stack_unit #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC   = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic [WIDTH-1:0]                   target,
  output logic [WIDTH-1:0]                   pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stk_err
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic             err_q;
  logic             err_d;
  logic             push;
  logic             full;
  logic             empty;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] stk_q [STACK_DEPTH];

  assign pc_inc  = pc_q + WIDTH'(1);
  assign full    = (depth_q == DW'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - DW'(1));

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    if (enable) begin
      if (jump) begin
        pc_d = target;
      end else if (call) begin
        if (full) begin
          err_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          push    = 1'b1;
          depth_d = depth_q + DW'(1);
          pc_d    = target;
        end
      end else if (ret) begin
        if (empty) begin
          err_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          depth_d = depth_q - DW'(1);
          pc_d    = stk_q[top_idx];
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset; entries above depth are never read.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      stk_q[wr_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stk_err     = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_stack_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned SD = 4;
  localparam logic [W-1:0] RV = 8'h00;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         jump;
  logic         call;
  logic         ret;
  logic [W-1:0] target;
  logic [W-1:0] pc;
  logic [2:0]   depth;
  logic         stack_full;
  logic         stack_empty;
  logic         stk_err;

  pc_stack_unit #(
    .WIDTH(W), .STACK_DEPTH(SD), .RESET_VEC(RV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .jump(jump), .call(call), .ret(ret), .target(target),
    .pc(pc), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: pc as 8-bit arithmetic, stack as a queue.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk [$];
  bit           m_err;
  bit           m_ok = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] nxt;
    nxt = m_pc + 8'd1;
    if (!reset) begin
      m_pc = RV;
      m_stk.delete();
      m_err = 1'b0;
      m_ok = 1'b1;
    end else if (m_ok && enable) begin
      if (jump) begin
        m_pc = target;
      end else if (call) begin
        if (m_stk.size() == SD) begin
          m_err = 1'b1;
          m_pc = nxt;
        end else begin
          m_stk.push_back(nxt);
          m_pc = target;
        end
      end else if (ret) begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
          m_pc = nxt;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else begin
        m_pc = nxt;
      end
    end
    #1;
    if (m_ok) begin
      chk("model_pc", int'(pc), int'(m_pc));
      chk("model_depth", int'(depth), m_stk.size());
      chk("model_full", int'(stack_full), int'(m_stk.size() == SD));
      chk("model_empty", int'(stack_empty), int'(m_stk.size() == 0));
      chk("model_err", int'(stk_err), int'(m_err));
    end
  end

  task automatic step(bit rs, bit en, bit j, bit c, bit r,
                      logic [W-1:0] t);
    @(negedge clk);
    reset = rs; enable = en; jump = j; call = c; ret = r; target = t;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; jump = 1'b0;
    call = 1'b0; ret = 1'b0; target = '0;

    // Reset then free-running increment with wrap.
    step(0, 1, 0, 0, 0, 8'h00);
    chk("rst_pc", int'(pc), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(stack_empty), 1);
    for (int k = 1; k <= 300; k++) begin
      step(1, 1, 0, 0, 0, 8'h00);
      if (k == 255) chk("wrap_255", int'(pc), 255);
      if (k == 256) chk("wrap_0", int'(pc), 0);
    end
    chk("inc_end_pc", int'(pc), 300 % 256);
    chk("inc_err", int'(stk_err), 0);

    // Stall ignores a pending jump.
    step(1, 1, 1, 0, 0, 8'h10);
    chk("stall_pre", int'(pc), 8'h10);
    for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 0, 8'h80);
    chk("stall_pc", int'(pc), 8'h10);
    chk("stall_err", int'(stk_err), 0);
    step(1, 1, 0, 0, 0, 8'h80);
    chk("stall_resume", int'(pc), 8'h11);

    // Nested call/return.
    step(1, 1, 1, 0, 0, 8'h20);
    step(1, 1, 0, 1, 0, 8'h40);
    chk("nest_c1_pc", int'(pc), 8'h40);
    chk("nest_c1_d", int'(depth), 1);
    step(1, 1, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 8'h00);
    chk("nest_42", int'(pc), 8'h42);
    step(1, 1, 0, 1, 0, 8'h60);
    chk("nest_c2_d", int'(depth), 2);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("nest_r1_pc", int'(pc), 8'h43);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("nest_r2_pc", int'(pc), 8'h21);
    chk("nest_r2_d", int'(depth), 0);
    chk("nest_err", int'(stk_err), 0);

    // Overflow then underflow.
    step(1, 1, 1, 0, 0, 8'hA0);
    step(1, 1, 0, 1, 0, 8'h10);
    step(1, 1, 0, 1, 0, 8'h20);
    step(1, 1, 0, 1, 0, 8'h30);
    step(1, 1, 0, 1, 0, 8'h40);
    chk("ovf_full", int'(stack_full), 1);
    step(1, 1, 0, 1, 0, 8'h50);
    chk("ovf_pc", int'(pc), 8'h41);
    chk("ovf_depth", int'(depth), 4);
    chk("ovf_err", int'(stk_err), 1);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("pop1", int'(pc), 8'h31);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("pop2", int'(pc), 8'h21);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("pop3", int'(pc), 8'h11);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("pop4", int'(pc), 8'hA1);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("unf_pc", int'(pc), 8'hA2);
    chk("unf_depth", int'(depth), 0);
    chk("unf_err", int'(stk_err), 1);

    // Priority.
    step(1, 1, 0, 1, 0, 8'h30);
    step(1, 1, 1, 1, 1, 8'h55);
    chk("prio_jump_pc", int'(pc), 8'h55);
    chk("prio_jump_d", int'(depth), 1);
    step(1, 1, 0, 1, 1, 8'h66);
    chk("prio_call_pc", int'(pc), 8'h66);
    chk("prio_call_d", int'(depth), 2);

    // Reset mid-operation with call asserted.
    step(1, 1, 0, 1, 0, 8'h70);
    chk("mid_pre_d", int'(depth), 3);
    step(0, 1, 0, 1, 0, 8'h70);
    chk("mid_pc", int'(pc), 0);
    chk("mid_depth", int'(depth), 0);
    chk("mid_err", int'(stk_err), 0);
    chk("mid_empty", int'(stack_empty), 1);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("mid_ret_err", int'(stk_err), 1);
    chk("mid_ret_pc", int'(pc), 1);

    // Call at the top address pushes 0.
    step(1, 1, 1, 0, 0, 8'hFF);
    step(1, 1, 0, 1, 0, 8'h12);
    chk("wcall_pc", int'(pc), 8'h12);
    step(1, 1, 0, 0, 1, 8'h00);
    chk("wret_pc", int'(pc), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           8'($urandom));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
